dcache_arbiter: RTL and testbench

- Sequences and shares the single-port data cache between two requesters: port 0 is the pipeline memory stage, port 1 is the debug/loader port.
- Arbitrates round-robin, latches the winning transaction, and holds memRead/memWrite steady for a fixed access window.
- Captures the cache's readData, then returns it with a one-cycle ack.
- Sits between the requesters and the data cache; the cache never sees two requesters at once.

---
 rtl/dcache_arbiter.sv | 133 +++++++++++++
 tb/tb_dcache_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_arbiter.sv
// Round-robin arbiter that shares a single-port data cache between the pipeline
// memory stage (port 0) and the debug/loader port (port 1).
module dcache_arbiter #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned AW      = 32
) (
  input  logic          clock,
  input  logic          reset,

  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] wdata0,
  output logic          ack0,
  output logic [AW-1:0] rdata0,

  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] wdata1,
  output logic          ack1,
  output logic [AW-1:0] rdata1,

  output logic          memRead,
  output logic          memWrite,
  output logic          memToReg,
  output logic [AW-1:0] cacheAddress,
  output logic [AW-1:0] cacheWriteData,
  input  logic [AW-1:0] cacheReadData,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e        state_q, state_d;
  logic          grant_q, grant_d;
  logic          last_grant_q, last_grant_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] wdata_q, wdata_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] rdata0_q, rdata0_d;
  logic [AW-1:0] rdata1_q, rdata1_d;

  // On contention the port that did not win last time goes next.
  logic pick;
  assign pick = (req0 & req1) ? ~last_grant_q : req1;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;

    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          grant_d      = pick;
          last_grant_d = pick;
          we_d         = pick ? we1    : we0;
          addr_d       = pick ? addr1  : addr0;
          wdata_d      = pick ? wdata1 : wdata0;
          cnt_d        = CNT_INIT;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (grant_q) rdata1_d = cacheReadData;
          else         rdata0_d = cacheReadData;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= 4'd0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  // Cache controls decode straight from registered state, so they are glitch-free
  // and stay constant for the whole access window.
  assign memRead        = (state_q == ACCESS) & ~we_q;
  assign memWrite       = (state_q == ACCESS) &  we_q;
  assign memToReg       = (state_q == ACCESS);
  assign cacheAddress   = addr_q;
  assign cacheWriteData = wdata_q;
  assign ack0           = (state_q == DONE) & ~grant_q;
  assign ack1           = (state_q == DONE) &  grant_q;
  assign rdata0         = rdata0_q;
  assign rdata1         = rdata1_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_dcache_arbiter.sv
// Bench for dcache_arbiter: transaction-phase reference model compared every cycle,
// directed scenarios with literal expectations, and a LATENCY=1 instance.
module tb_dcache_arbiter;

  localparam int L = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, ack1, memRead, memWrite, memToReg, busy;
  logic [31:0] rdata0, rdata1, cacheAddress, cacheWriteData, cacheReadData;

  logic        req0_b, we0_b, req1_b, we1_b;
  logic [31:0] addr0_b, wdata0_b, addr1_b, wdata1_b;
  logic        ack0_b, ack1_b, memRead_b, memWrite_b, memToReg_b, busy_b;
  logic [31:0] rdata0_b, rdata1_b, cacheAddress_b, cacheWriteData_b, cacheReadData_b;

  always #5 clock = ~clock;

  dcache_arbiter #(.LATENCY(L), .AW(32)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .memRead(memRead), .memWrite(memWrite), .memToReg(memToReg),
    .cacheAddress(cacheAddress), .cacheWriteData(cacheWriteData),
    .cacheReadData(cacheReadData), .busy(busy)
  );

  dcache_arbiter #(.LATENCY(1), .AW(32)) dut1 (
    .clock(clock), .reset(reset),
    .req0(req0_b), .we0(we0_b), .addr0(addr0_b), .wdata0(wdata0_b), .ack0(ack0_b), .rdata0(rdata0_b),
    .req1(req1_b), .we1(we1_b), .addr1(addr1_b), .wdata1(wdata1_b), .ack1(ack1_b), .rdata1(rdata1_b),
    .memRead(memRead_b), .memWrite(memWrite_b), .memToReg(memToReg_b),
    .cacheAddress(cacheAddress_b), .cacheWriteData(cacheWriteData_b),
    .cacheReadData(cacheReadData_b), .busy(busy_b)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Bench-side cache: echoes write data while writing, otherwise reads its array.
  logic [31:0] cmem [1024];
  logic [31:0] gmem [1024];
  assign cacheReadData   = memWrite ? cacheWriteData : cmem[cacheAddress[11:2]];
  assign cacheReadData_b = 32'h1234_5678;

  always @(posedge clock) begin
    if (memWrite) cmem[cacheAddress[11:2]] = cacheWriteData;
  end

  // Reference model: phase 0 idle, phases 1..L the access window, L+1 the ack cycle.
  int          m_phase;
  logic        m_gid, m_last, m_we;
  logic [31:0] m_addr, m_wdata, m_rd0, m_rd1;

  always @(posedge clock) begin
    if (reset) begin
      m_phase = 0; m_last = 1'b1; m_gid = 1'b0; m_we = 1'b0;
      m_addr = '0; m_wdata = '0; m_rd0 = '0; m_rd1 = '0;
    end else if (m_phase == 0) begin
      if (req0 || req1) begin
        if (req0 && req1) m_gid = (m_last == 1'b1) ? 1'b0 : 1'b1;
        else              m_gid = req1 ? 1'b1 : 1'b0;
        m_last  = m_gid;
        m_we    = m_gid ? we1 : we0;
        m_addr  = m_gid ? addr1 : addr0;
        m_wdata = m_gid ? wdata1 : wdata0;
        m_phase = 1;
      end
    end else if (m_phase == L) begin
      logic [31:0] v;
      if (m_we) begin
        gmem[m_addr[11:2]] = m_wdata;
        v = m_wdata;
      end else begin
        v = gmem[m_addr[11:2]];
      end
      if (m_gid) m_rd1 = v; else m_rd0 = v;
      m_phase = L + 1;
    end else if (m_phase == L + 1) begin
      m_phase = 0;
    end else begin
      m_phase = m_phase + 1;
    end
  end

  int ack_port[$];
  int ack_cyc[$];
  int strobe_log[$];
  int strobe_cnt = 0;
  int n_ack1 = 0;

  always @(posedge clock) begin
    logic acc;
    #1;
    acc = (m_phase >= 1) && (m_phase <= L);
    check("memRead",        32'(memRead),  32'(acc && !m_we));
    check("memWrite",       32'(memWrite), 32'(acc && m_we));
    check("memToReg",       32'(memToReg), 32'(acc));
    check("busy",           32'(busy),     32'(m_phase != 0));
    check("ack0",           32'(ack0),     32'(m_phase == L + 1 && m_gid == 1'b0));
    check("ack1",           32'(ack1),     32'(m_phase == L + 1 && m_gid == 1'b1));
    check("cacheAddress",   cacheAddress,   m_addr);
    check("cacheWriteData", cacheWriteData, m_wdata);
    check("rdata0",         rdata0,         m_rd0);
    check("rdata1",         rdata1,         m_rd1);
    if (memRead || memWrite) strobe_cnt++;
    if (ack0) begin ack_port.push_back(0); ack_cyc.push_back(cyc); end
    if (ack1) begin ack_port.push_back(1); ack_cyc.push_back(cyc); n_ack1++; end
    if (ack0 || ack1) begin strobe_log.push_back(strobe_cnt); strobe_cnt = 0; end
    if (reset) strobe_cnt = 0;
  end

  // LATENCY=1 instance never uses port 1 or writes; any activity there is an error.
  logic stray_b = 1'b0;
  always @(negedge clock) begin
    if (!reset && (memWrite_b || ack1_b || (rdata1_b != 32'h0) || (memToReg_b != memRead_b)))
      stray_b <= 1'b1;
  end

  task automatic wait_ack(input int port, input int bound, output int at_cyc);
    bit seen = 1'b0;
    at_cyc = -1;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clock);
      if ((port == 0) ? ack0 : ack1) begin
        seen = 1'b1;
        at_cyc = cyc;
      end
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_ack%0d: no ack within %0d cycles", port, bound);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, ac, n0;
    int got;
    logic [3:0] mr, ak, bz;

    for (int i = 0; i < 1024; i++) gmem[i] = 32'hA500_0000 | 32'(i);
    gmem[10'h140] = 32'h0101_0101;
    for (int i = 0; i < 1024; i++) cmem[i] = gmem[i];

    reset = 1'b1;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    req0_b = 0; we0_b = 0; addr0_b = '0; wdata0_b = '0;
    req1_b = 0; we1_b = 0; addr1_b = '0; wdata1_b = '0;
    repeat (3) @(negedge clock);
    check("rst_busy",  32'(busy), 32'h0);
    check("rst_ack0",  32'(ack0), 32'h0);
    check("rst_addr",  cacheAddress, 32'h0);
    check("rst_rdata", rdata0, 32'h0);
    reset = 1'b0;
    @(negedge clock);

    // Single port-0 read.
    req0 = 1; we0 = 0; addr0 = 32'h500; c0 = cyc;
    wait_ack(0, 20, ac);
    req0 = 0;
    check("t1_latency", 32'(ac - c0), 32'd5);
    check("t1_rdata0",  rdata0, 32'h0101_0101);
    check("t1_strobes", 32'(strobe_log[$]), 32'd4);
    check("t1_no_ack1", 32'(n_ack1), 32'd0);
    @(negedge clock);

    // Port-1 write, then port-0 read-back of the same word.
    req1 = 1; we1 = 1; addr1 = 32'h508; wdata1 = 32'hCAFE_F00D;
    wait_ack(1, 20, ac);
    req1 = 0;
    check("t2_rdata1",  rdata1, 32'hCAFE_F00D);
    check("t2_wdata",   cacheWriteData, 32'hCAFE_F00D);
    check("t2_strobes", 32'(strobe_log[$]), 32'd4);
    @(negedge clock);
    req0 = 1; we0 = 0; addr0 = 32'h508;
    wait_ack(0, 20, ac);
    req0 = 0;
    check("t2_readback", rdata0, 32'hCAFE_F00D);
    @(negedge clock);

    // Both ports held from the first cycle after reset.
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    req0 = 1; we0 = 0; addr0 = 32'h500;
    req1 = 1; we1 = 0; addr1 = 32'h508;
    n0 = ack_port.size();
    got = 0;
    for (int i = 0; i < 80 && got < 4; i++) begin
      @(negedge clock);
      if (ack0 || ack1) got++;
    end
    req0 = 0; req1 = 0;
    check("t3_acks", 32'(got), 32'd4);
    check("t3_ackcycles", 32'(ack_port.size() - n0), 32'd4);
    for (int k = 0; k < 4; k++) check("t3_order", 32'(ack_port[n0 + k]), 32'(k % 2));
    for (int k = 1; k < 4; k++) check("t3_spacing", 32'(ack_cyc[n0 + k] - ack_cyc[n0 + k - 1]), 32'd6);
    @(negedge clock);

    // Requester changes address and drops req mid-access.
    req0 = 1; we0 = 0; addr0 = 32'h500;
    n0 = ack_port.size();
    repeat (2) @(negedge clock);
    addr0 = 32'h540; req0 = 0;
    wait_ack(0, 20, ac);
    check("t4_addr",  cacheAddress, 32'h500);
    check("t4_rdata", rdata0, 32'h0101_0101);
    repeat (10) @(negedge clock);
    check("t4_one_ack", 32'(ack_port.size() - n0), 32'd1);

    // Reset in access cycle 2 aborts without an ack.
    req0 = 1; we0 = 0; addr0 = 32'h504;
    n0 = ack_port.size();
    repeat (2) @(negedge clock);
    reset = 1'b1; req0 = 0;
    @(negedge clock);
    check("t5_busy",    32'(busy), 32'h0);
    check("t5_memRead", 32'(memRead), 32'h0);
    check("t5_addr",    cacheAddress, 32'h0);
    check("t5_rdata0",  rdata0, 32'h0);
    reset = 1'b0;
    repeat (8) @(negedge clock);
    check("t5_no_ack", 32'(ack_port.size() - n0), 32'd0);
    req0 = 1; we0 = 0; addr0 = 32'h500; c0 = cyc;
    wait_ack(0, 20, ac);
    req0 = 0;
    check("t5_latency", 32'(ac - c0), 32'd5);
    check("t5_rdata",   rdata0, 32'h0101_0101);
    check("t5_strobes", 32'(strobe_log[$]), 32'd4);
    @(negedge clock);

    // LATENCY=1 instance: one read.
    req0_b = 1; we0_b = 0; addr0_b = 32'h10; wdata0_b = 32'h77;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      mr[k] = memRead_b; ak[k] = ack0_b; bz[k] = busy_b;
      if (ack0_b) req0_b = 0;
    end
    req0_b = 0;
    check("l1_memRead", 32'(mr), 32'b0001);
    check("l1_ack0",    32'(ak), 32'b0010);
    check("l1_busy",    32'(bz), 32'b0011);
    check("l1_rdata0",  rdata0_b, 32'h1234_5678);
    check("l1_addr",    cacheAddress_b, 32'h10);
    check("l1_wdata",   cacheWriteData_b, 32'h77);
    check("l1_stray",   32'(stray_b), 32'h0);

    repeat (2) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
